// File: rtl/temporizador_bcd_if.sv
// Control/data bundle for the BCD countdown timer: load, run control and count outputs.
interface temporizador_bcd_if;
   logic       tick;
   logic       load;
   logic [7:0] hora_in;
   logic [7:0] minuto_in;
   logic [7:0] segundo_in;
   logic       start;
   logic       stop;
   logic       ack;
   logic [7:0] hora_out;
   logic [7:0] minuto_out;
   logic [7:0] segundo_out;
   logic       running;
   logic       alarma;
   logic       load_err;

   modport master (
      output tick, load, hora_in, minuto_in, segundo_in, start, stop, ack,
      input  hora_out, minuto_out, segundo_out, running, alarma, load_err
   );

   modport slave (
      input  tick, load, hora_in, minuto_in, segundo_in, start, stop, ack,
      output hora_out, minuto_out, segundo_out, running, alarma, load_err
   );
endinterface

// File: rtl/temporizador_bcd.sv
// hh:mm:ss countdown kept directly in packed BCD, one decrement per 1 Hz tick.
// Define AUTORECARGA_EN to reload from the last valid load on reaching zero instead of alarming.
module temporizador_bcd #(
   parameter int unsigned ALARM_TICKS = 10
) (
   input logic               clk,
   input logic               reset,
   temporizador_bcd_if.slave bus
);

   typedef enum logic [1:0] {IDLE, RUN, PAUSE, ALARM} state_t;

   localparam int unsigned CW = (ALARM_TICKS > 1) ? $clog2(ALARM_TICKS) : 1;

   state_t        state, state_n;
   logic [7:0]    hh, mm, ss, hh_n, mm_n, ss_n;
   logic [7:0]    rl_h, rl_m, rl_s, rl_h_n, rl_m_n, rl_s_n;
   logic [CW-1:0] cnt, cnt_n;
   logic          alarma_q, alarma_n;
   logic          lerr_q, lerr_n;
   logic          load_ok, load_allowed, count_zero, count_one;

   // Wrap value is returned when decrementing from 00 (borrow into the next field).
   function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] wrap);
      if (v == 8'h00) return wrap;
      if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
      return {v[7:4], v[3:0] - 4'd1};
   endfunction

   function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] max);
      return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max);
   endfunction

   assign load_ok      = bcd_ok(bus.hora_in, 8'h23) && bcd_ok(bus.minuto_in, 8'h59) &&
                         bcd_ok(bus.segundo_in, 8'h59);
   assign load_allowed = bus.load && (state != RUN);
   assign count_zero   = (hh == 8'h00) && (mm == 8'h00) && (ss == 8'h00);
   assign count_one    = (hh == 8'h00) && (mm == 8'h00) && (ss == 8'h01);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         hh       <= '0;
         mm       <= '0;
         ss       <= '0;
         rl_h     <= '0;
         rl_m     <= '0;
         rl_s     <= '0;
         cnt      <= '0;
         alarma_q <= 1'b0;
         lerr_q   <= 1'b0;
      end else begin
         state    <= state_n;
         hh       <= hh_n;
         mm       <= mm_n;
         ss       <= ss_n;
         rl_h     <= rl_h_n;
         rl_m     <= rl_m_n;
         rl_s     <= rl_s_n;
         cnt      <= cnt_n;
         alarma_q <= alarma_n;
         lerr_q   <= lerr_n;
      end
   end

   always_comb begin
      state_n  = state;
      hh_n     = hh;
      mm_n     = mm;
      ss_n     = ss;
      rl_h_n   = rl_h;
      rl_m_n   = rl_m;
      rl_s_n   = rl_s;
      cnt_n    = cnt;
      alarma_n = alarma_q;
      lerr_n   = 1'b0;
`ifdef AUTORECARGA_EN
      alarma_n = 1'b0;
`endif
      if (load_allowed && load_ok) begin
         hh_n     = bus.hora_in;
         mm_n     = bus.minuto_in;
         ss_n     = bus.segundo_in;
         rl_h_n   = bus.hora_in;
         rl_m_n   = bus.minuto_in;
         rl_s_n   = bus.segundo_in;
         cnt_n    = '0;
         alarma_n = 1'b0;
         state_n  = IDLE;
      end else begin
         // A rejected load only flags the error; same-cycle start/stop still act.
         lerr_n = load_allowed;
         unique case (state)
            IDLE, PAUSE: begin
               if (!bus.stop && bus.start && !count_zero) state_n = RUN;
            end
            RUN: begin
               if (bus.stop) begin
                  state_n = PAUSE;
               end else if (bus.tick) begin
                  if (count_one) begin
`ifdef AUTORECARGA_EN
                     hh_n     = rl_h;
                     mm_n     = rl_m;
                     ss_n     = rl_s;
                     alarma_n = 1'b1;
`else
                     hh_n     = '0;
                     mm_n     = '0;
                     ss_n     = '0;
                     cnt_n    = '0;
                     alarma_n = 1'b1;
                     state_n  = ALARM;
`endif
                  end else begin
                     ss_n = bcd_dec(ss, 8'h59);
                     if (ss == 8'h00) mm_n = bcd_dec(mm, 8'h59);
                     if ((ss == 8'h00) && (mm == 8'h00)) hh_n = bcd_dec(hh, 8'h23);
                  end
               end
            end
            ALARM: begin
               if (bus.ack) begin
                  alarma_n = 1'b0;
                  cnt_n    = '0;
                  state_n  = IDLE;
               end else if ((ALARM_TICKS > 0) && bus.tick) begin
                  if (cnt == CW'(ALARM_TICKS - 1)) begin
                     alarma_n = 1'b0;
                     cnt_n    = '0;
                     state_n  = IDLE;
                  end else begin
                     cnt_n = cnt + CW'(1);
                  end
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   assign bus.hora_out    = hh;
   assign bus.minuto_out  = mm;
   assign bus.segundo_out = ss;
   assign bus.running     = (state == RUN);
   assign bus.alarma      = alarma_q;
   assign bus.load_err    = lerr_q;

endmodule
